// File: rtl/viterbi_dec_k3_if.sv
// Symbol/decision bus of the K=3 hard-decision Viterbi decoder.
// master = symbol source (deinterleaver side), slave = decoder.
interface viterbi_dec_k3_if #(
    parameter int PM_W = 6
);
    logic            sync_clr;
    logic            in_valid;
    logic [1:0]      data_in;
    logic            out_valid;
    logic            data_out;
    logic [PM_W-1:0] metric_min;

    modport master (
        output sync_clr, in_valid, data_in,
        input  out_valid, data_out, metric_min
    );

    modport slave (
        input  sync_clr, in_valid, data_in,
        output out_valid, data_out, metric_min
    );
endinterface

// File: rtl/viterbi_dec_k3.sv
// Hard-decision Viterbi decoder, rate 1/2, K=3 (G0=111, G1=101),
// register-exchange survivor memory of TB_DEPTH symbols.
module viterbi_dec_k3 #(
    parameter int TB_DEPTH = 16,
    parameter int PM_W     = 6
) (
    input logic             clk,
    input logic             rst_n,
    viterbi_dec_k3_if.slave bus
);

    localparam int CNT_W = $clog2(TB_DEPTH + 1);
    localparam logic [PM_W-1:0]  PM_INIT = {2'b01, {(PM_W-2){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TB_DEPTH);
    localparam logic [CNT_W-1:0] CNT_OUT = CNT_W'(TB_DEPTH - 1);

    logic [PM_W-1:0]     pm_q   [4];
    logic [PM_W-1:0]     pm_d   [4];
    logic [TB_DEPTH-1:0] path_q [4];
    logic [TB_DEPTH-1:0] path_d [4];
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                out_valid_q, out_valid_d;
    logic                data_out_q, data_out_d;
    logic [PM_W-1:0]     metric_min_q, metric_min_d;

    // ACS scratch
    logic [PM_W-1:0]     pm_new   [4];
    logic [TB_DEPTH-1:0] path_new [4];
    logic [PM_W-1:0]     cand0, cand1, min_v;
    logic [1:0]          pred0, pred1, best;
    logic                bit_a, bit_b, all_msb;

    // Hamming distance between the received symbol and the branch label
    function automatic logic [1:0] branch_metric(
        input logic [1:0] sym,
        input logic       a,
        input logic       b,
        input logic       c
    );
        logic c0, c1;
        c0 = a ^ b ^ c;
        c1 = a ^ c;
        return {1'b0, sym[1] ^ c0} + {1'b0, sym[0] ^ c1};
    endfunction

    // Add-compare-select, normalisation, best-state pick and next-state selection
    always_comb begin
        pm_d         = pm_q;
        path_d       = path_q;
        cnt_d        = cnt_q;
        out_valid_d  = 1'b0;
        data_out_d   = data_out_q;
        metric_min_d = metric_min_q;
        pm_new       = pm_q;
        path_new     = path_q;
        cand0        = '0;
        cand1        = '0;
        pred0        = '0;
        pred1        = '0;
        bit_a        = 1'b0;
        bit_b        = 1'b0;

        for (int unsigned ns = 0; ns < 4; ns++) begin
            bit_a = 1'(ns >> 1);
            bit_b = 1'(ns);
            pred0 = {bit_b, 1'b0};
            pred1 = {bit_b, 1'b1};
            cand0 = pm_q[pred0] + PM_W'(branch_metric(bus.data_in, bit_a, bit_b, 1'b0));
            cand1 = pm_q[pred1] + PM_W'(branch_metric(bus.data_in, bit_a, bit_b, 1'b1));
            // ties resolve toward the {b,0} predecessor
            if (cand1 < cand0) begin
                pm_new[ns]   = cand1;
                path_new[ns] = {path_q[pred1][TB_DEPTH-2:0], bit_a};
            end else begin
                pm_new[ns]   = cand0;
                path_new[ns] = {path_q[pred0][TB_DEPTH-2:0], bit_a};
            end
        end

        // metrics only ever climb; once all four sit in the top half, drop them together
        all_msb = pm_new[0][PM_W-1] & pm_new[1][PM_W-1] &
                  pm_new[2][PM_W-1] & pm_new[3][PM_W-1];
        if (all_msb) begin
            for (int unsigned i = 0; i < 4; i++) begin
                pm_new[i][PM_W-1] = 1'b0;
            end
        end

        min_v = pm_new[0];
        best  = 2'd0;
        for (int unsigned i = 1; i < 4; i++) begin
            if (pm_new[i] < min_v) begin
                min_v = pm_new[i];
                best  = 2'(i);
            end
        end

        if (bus.sync_clr) begin
            pm_d         = '{'0, PM_INIT, PM_INIT, PM_INIT};
            path_d       = '{default: '0};
            cnt_d        = '0;
            data_out_d   = 1'b0;
            metric_min_d = '0;
        end else if (bus.in_valid) begin
            pm_d         = pm_new;
            path_d       = path_new;
            metric_min_d = min_v;
            out_valid_d  = (cnt_q >= CNT_OUT);
            data_out_d   = path_new[best][TB_DEPTH-1];
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with asynchronous reset to the known start state 00
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pm_q         <= '{'0, PM_INIT, PM_INIT, PM_INIT};
            path_q       <= '{default: '0};
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            data_out_q   <= 1'b0;
            metric_min_q <= '0;
        end else begin
            pm_q         <= pm_d;
            path_q       <= path_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            data_out_q   <= data_out_d;
            metric_min_q <= metric_min_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.data_out   = data_out_q;
    assign bus.metric_min = metric_min_q;

endmodule

// File: tb/tb_viterbi_dec_k3.sv
// Scoreboard bench for viterbi_dec_k3: a traceback-style reference decoder
// predicts every output; a free-running monitor checks each out_valid pulse.
module tb_viterbi_dec_k3;

    localparam int TB_DEPTH = 16;
    localparam int PM_W     = 6;
    localparam int HALF     = 1 << (PM_W - 1);
    localparam int QUART    = 1 << (PM_W - 2);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    viterbi_dec_k3_if #(.PM_W(PM_W)) bus ();

    viterbi_dec_k3 #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int bit_v;
        int mm;
        int src;
        bit chk;
    } exp_t;

    exp_t       exp_q [$];
    int         vectors     = 0;
    int         miscompares = 0;

    // reference decoder state: unbounded metrics plus a normalisation offset
    int         m_pm [4];
    int         m_off;
    int         m_cnt;
    logic [3:0] m_dec [$];
    int         m_src [$];
    logic [1:0] enc_s;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_pm  = '{0, QUART, QUART, QUART};
        m_off = 0;
        m_cnt = 0;
        m_dec.delete();
        m_src.delete();
        enc_s = 2'b00;
    endtask

    task automatic model_step(input logic [1:0] sym, input int src, input bit chk);
        int         npm [4];
        logic [3:0] dec;
        int         a, b, c0, c1, p, bm, m, bestm, best, mn, s;
        exp_t       e;
        dec = '0;
        for (int ns = 0; ns < 4; ns++) begin
            a = ns >> 1;
            b = ns & 1;
            bestm = 0;
            for (int c = 0; c < 2; c++) begin
                p  = b * 2 + c;
                c0 = a ^ b ^ c;
                c1 = a ^ c;
                bm = ((int'(sym[1]) != c0) ? 1 : 0) + ((int'(sym[0]) != c1) ? 1 : 0);
                m  = m_pm[p] + bm;
                if (c == 0 || m < bestm) begin
                    bestm   = m;
                    dec[ns] = (c == 1);
                end
            end
            npm[ns] = bestm;
        end
        m_pm = npm;
        if (m_pm[0] - m_off >= HALF && m_pm[1] - m_off >= HALF &&
            m_pm[2] - m_off >= HALF && m_pm[3] - m_off >= HALF)
            m_off += HALF;
        mn = m_pm[0];
        best = 0;
        for (int i = 1; i < 4; i++) begin
            if (m_pm[i] < mn) begin
                mn = m_pm[i];
                best = i;
            end
        end
        m_dec.push_back(dec);
        if (m_dec.size() > TB_DEPTH) void'(m_dec.pop_front());
        m_src.push_back(src);
        if (m_cnt >= TB_DEPTH - 1) begin
            // walk the survivor back TB_DEPTH-1 decisions from the best state
            s = best;
            for (int i = 0; i < TB_DEPTH - 1; i++) begin
                dec = m_dec[m_dec.size() - 1 - i];
                s = ((s & 1) << 1) | int'(dec[s]);
            end
            e.bit_v = s >> 1;
            e.mm    = mn - m_off;
            e.src   = m_src.pop_front();
            e.chk   = chk;
            exp_q.push_back(e);
        end
        if (m_cnt < TB_DEPTH) m_cnt++;
    endtask

    task automatic encode(input logic u, output logic [1:0] sym);
        sym   = {u ^ enc_s[1] ^ enc_s[0], u ^ enc_s[0]};
        enc_s = {u, enc_s[1]};
    endtask

    task automatic drive(input logic v, input logic [1:0] sym, input logic clr,
                         input int src, input bit chk);
        @(negedge clk);
        bus.in_valid = v;
        bus.data_in  = sym;
        bus.sync_clr = clr;
        if (clr) model_reset();
        else if (v) model_step(sym, src, chk);
    endtask

    task automatic send_bit(input logic u, input bit flip, input bit inv,
                            input bit chk, input int gap);
        logic [1:0] sym;
        encode(u, sym);
        if (flip) sym[1] = ~sym[1];
        if (inv)  sym = ~sym;
        drive(1'b1, sym, 1'b0, int'(u), chk);
        repeat (gap) drive(1'b0, 2'b00, 1'b0, 0, 1'b0);
    endtask

    // monitor: every out_valid pulse must match the next scoreboard entry
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_out_valid: got 1 expected 0 at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("data_out", 32'(bus.data_out), 32'(e.bit_v));
                check("metric_min", 32'(bus.metric_min), 32'(e.mm));
                if (e.chk) check("data_out_vs_source", 32'(bus.data_out), 32'(e.src));
            end
        end else if (bus.out_valid !== 1'b0) begin
            check("out_valid_known", 32'(bus.out_valid), 32'(0));
        end
    end

    initial begin
        int src4 [4];
        src4 = '{1, 0, 1, 1};
        bus.in_valid = 1'b0;
        bus.data_in  = 2'b00;
        bus.sync_clr = 1'b0;
        model_reset();

        // power-on reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_data_out", 32'(bus.data_out), 0);
        check("rst_metric_min", 32'(bus.metric_min), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // clean stream 1,0,1,1 then zeros
        for (int i = 0; i < 4; i++) send_bit(1'(src4[i]), 1'b0, 1'b0, 1'b1, 0);
        for (int i = 0; i < 28; i++) send_bit(1'b0, 1'b0, 1'b0, 1'b1, 0);

        // random source, random idle gaps, noise-free
        for (int i = 0; i < 300; i++)
            send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1, $urandom_range(0, 5));

        // every 11th symbol has its G0 bit flipped
        for (int i = 0; i < 500; i++)
            send_bit(1'($urandom_range(0, 1)), (i % 11) == 10, 1'b0, 1'b0, 0);

        // asynchronous reset mid-run, away from a clock edge
        drive(1'b0, 2'b00, 1'b0, 0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(bus.out_valid), 0);
        check("async_rst_data_out", 32'(bus.data_out), 0);
        check("async_rst_metric_min", 32'(bus.metric_min), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // fully inverted symbols drive the metrics through normalisation
        for (int i = 0; i < 2000; i++)
            send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0, 0);

        // clean traffic, then sync_clr collides with a valid symbol
        for (int i = 0; i < 40; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 0);
        drive(1'b1, 2'b11, 1'b1, 0, 1'b0);
        @(posedge clk);
        #2;
        check("clr_out_valid", 32'(bus.out_valid), 0);
        check("clr_data_out", 32'(bus.data_out), 0);
        check("clr_metric_min", 32'(bus.metric_min), 0);
        for (int i = 0; i < 40; i++)
            send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1, $urandom_range(0, 2));

        repeat (4) drive(1'b0, 2'b00, 1'b0, 0, 1'b0);
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/viterbi_dec_k3.md
Name: viterbi_dec_k3

Overview:
Hard-decision Viterbi decoder for the rate-1/2, constraint-length-3 convolutional code (generators G0=111, G1=101) produced by the team's encoder. It accepts one 2-bit code symbol per in_valid strobe and emits one decoded data bit per symbol after a fixed decision depth. It uses register-exchange survivor memory. It sits after the noisy-channel deinterleave buffer, in the slow symbol-clock domain of the codec chain.

Parameters:
TB_DEPTH, 16, survivor register length in symbols (decision depth); legal range 8..32.
PM_W, 6, path-metric width in bits; PM_W >= 5.

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst_n  input  1  asynchronous active-low reset
sync_clr  input  1  synchronous restart; same effect as reset, on the next rising edge
in_valid  input  1  data_in holds a new code symbol this cycle
data_in  input  2  code symbol; [1]=G0 output (first transmitted bit), [0]=G1 output
out_valid  output  1  data_out holds a decoded bit; one-cycle pulse
data_out  output  1  decoded data bit
metric_min  output  PM_W  smallest current path metric (channel-quality monitor)

Behaviour:
- Encoder model: state s={u[n-1],u[n-2]}, start state 00.
  - c0 = u^u[n-1]^u[n-2]; c1 = u^u[n-2].
  - Next state ns={u,u[n-1]}.
- Branch metric: Hamming distance between data_in and the expected {c0,c1}; range 0..2.
- ACS, performed only on cycles with in_valid=1:
  - ns={a,b} has predecessors {b,0} and {b,1}; the decoded bit for that branch is a.
  - New PM[ns] = min over predecessors of PM[pred] + BM.
  - On a tie, choose predecessor {b,0}.
- Normalisation: if all four new metrics have their MSB set, clear the MSB of all four in the same update. Metrics never wrap or saturate otherwise.
- Survivors: path[ns] <= {path[pred][TB_DEPTH-2:0], a}.
  - path[s][0] is the newest bit; path[s][TB_DEPTH-1] is the oldest.
- Output selection:
  - best = lowest-index state holding the minimum new metric.
  - data_out <= path_new[best][TB_DEPTH-1], registered.
- Fill counter:
  - Counts accepted symbols, saturating at TB_DEPTH.
  - out_valid <= in_valid and (count_before_update >= TB_DEPTH-1).
  - The first out_valid occurs on the TB_DEPTH-th symbol and carries source bit 0.
- Latency:
  - out_valid/data_out are asserted in the cycle after the in_valid cycle (registered).
  - Bit k appears with symbol k+TB_DEPTH-1.
- in_valid=0: metrics, survivors and counter hold. out_valid=0. data_out holds its last value.
- metric_min: registered min of the new metrics; updates with each accepted symbol.
- Reset or sync_clr:
  - PM[0]=0; PM[1..3]=2^(PM_W-2).
  - All survivors 0; counter 0.
  - out_valid=0, data_out=0, metric_min=0.
  - sync_clr wins over a simultaneous in_valid; that symbol is discarded.
- No backpressure: the downstream block must accept every out_valid pulse.
- Trailing bits: trailing TB_DEPTH-1 source bits are only flushed by feeding the encoder's zero-tail symbols.

Test Plan:
- Reset: assert rst_n=0 mid-run → out_valid=0, data_out=0, metric_min=0 immediately (async); after release, first out_valid only after the 16th symbol.
- Clean stream: source 1,0,1,1 followed by zeros, encoded as 11,10,00,01,01,11,00,00… → decoded bits 1,0,1,1,0… starting at symbol 16; metric_min stays 0.
- Noise injection: flip bit [1] of every 11th symbol over 500 random source bits → decoded stream equals the source exactly; metric_min increments by 1 per error before normalisation.
- Gapped valid: random in_valid duty (0–5 idle cycles between symbols) → decoded sequence identical to the gapless run; out_valid pulses exactly once per accepted symbol from symbol 16 onward.
- Normalisation: 2000 symbols of all-inverted data_in (11↔00, 10↔01) → no metric wrap; MSB clear events observed; metric_min always < 2^(PM_W-1) after each update.
- sync_clr asserted together with in_valid mid-stream → that symbol is dropped; decoding restarts from state 00 and the first out_valid arrives 16 symbols later.
